// File: rtl/rob_multi_if.sv
// Dispatch / completion / retirement bundle for rob_multi.
// master = dispatch, CDB and RRF side; slave = the reorder buffer.
interface rob_multi_if #(
    parameter int QUEUE_DEPTH    = 64,
    parameter int PHYS_REG_WIDTH = 6,
    parameter int ARCH_REG_WIDTH = 5,
    parameter int CDB_PORTS      = 2,
    parameter int COMMIT_WIDTH   = 2
);
    localparam int ADDR_W = $clog2(QUEUE_DEPTH);

    logic                                         enqueue_valid;
    logic [PHYS_REG_WIDTH-1:0]                    phys_reg_in;
    logic [ARCH_REG_WIDTH-1:0]                    arch_reg_in;
    logic                                         enqueue_ready;
    logic [ADDR_W-1:0]                            rob_num;
    logic [CDB_PORTS-1:0]                         cdb_valid;
    logic [CDB_PORTS-1:0][ADDR_W-1:0]             cdb_rob_idx;
    logic [COMMIT_WIDTH-1:0]                      commit_valid;
    logic [COMMIT_WIDTH-1:0][PHYS_REG_WIDTH-1:0]  commit_phys;
    logic [COMMIT_WIDTH-1:0][ARCH_REG_WIDTH-1:0]  commit_arch;
    logic                                         full;
    logic                                         empty;
    logic [ADDR_W:0]                              count;

    modport master (
        output enqueue_valid, phys_reg_in, arch_reg_in, cdb_valid, cdb_rob_idx,
        input  enqueue_ready, rob_num, commit_valid, commit_phys, commit_arch,
               full, empty, count
    );

    modport slave (
        input  enqueue_valid, phys_reg_in, arch_reg_in, cdb_valid, cdb_rob_idx,
        output enqueue_ready, rob_num, commit_valid, commit_phys, commit_arch,
               full, empty, count
    );
endinterface

// File: rtl/rob_multi.sv
// Multi-port reorder buffer: one allocation per cycle, CDB_PORTS completions,
// up to COMMIT_WIDTH in-order retirements. Define ROB_FLUSH_EN for the flush input.
module rob_multi #(
    parameter int QUEUE_DEPTH    = 64,
    parameter int PHYS_REG_WIDTH = 6,
    parameter int ARCH_REG_WIDTH = 5,
    parameter int CDB_PORTS      = 2,
    parameter int COMMIT_WIDTH   = 2
) (
    input logic        clk,
    input logic        rst,
`ifdef ROB_FLUSH_EN
    input logic        flush,
`endif
    rob_multi_if.slave bus
);
    localparam int              ADDR_W  = $clog2(QUEUE_DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

    logic [ADDR_W:0]                             head_q, head_d;
    logic [ADDR_W:0]                             tail_q, tail_d;
    logic [QUEUE_DEPTH-1:0]                      valid_q, valid_d;
    logic [QUEUE_DEPTH-1:0]                      ready_q, ready_d;
    logic [PHYS_REG_WIDTH-1:0]                   phys_q [QUEUE_DEPTH];
    logic [PHYS_REG_WIDTH-1:0]                   phys_d [QUEUE_DEPTH];
    logic [ARCH_REG_WIDTH-1:0]                   arch_q [QUEUE_DEPTH];
    logic [ARCH_REG_WIDTH-1:0]                   arch_d [QUEUE_DEPTH];

    logic [ADDR_W-1:0]                           lane_idx [COMMIT_WIDTH];
    logic [COMMIT_WIDTH-1:0]                     commit_valid;
    logic [COMMIT_WIDTH-1:0][PHYS_REG_WIDTH-1:0] commit_phys;
    logic [COMMIT_WIDTH-1:0][ARCH_REG_WIDTH-1:0] commit_arch;
    logic [ADDR_W:0]                             num_commit;
    logic                                        scan_run;
    logic                                        full;
    logic                                        do_enq;
    logic                                        flush_now;

`ifdef ROB_FLUSH_EN
    assign flush_now = flush;
`else
    assign flush_now = 1'b0;
`endif

    assign full   = (tail_q[ADDR_W-1:0] == head_q[ADDR_W-1:0]) && (tail_q[ADDR_W] != head_q[ADDR_W]);
    assign do_enq = bus.enqueue_valid && !full;

    assign bus.full          = full;
    assign bus.empty         = (head_q == tail_q);
    assign bus.count         = tail_q - head_q;
    assign bus.enqueue_ready = !full;
    assign bus.rob_num       = tail_q[ADDR_W-1:0];
    assign bus.commit_valid  = commit_valid;
    assign bus.commit_phys   = commit_phys;
    assign bus.commit_arch   = commit_arch;

    // Lane addresses wrap naturally because they are only ADDR_W bits wide.
    for (genvar k = 0; k < COMMIT_WIDTH; k++) begin : g_lane
        assign lane_idx[k] = head_q[ADDR_W-1:0] + ADDR_W'(k);
    end

    always_comb begin
        commit_valid = '0;
        commit_phys  = '0;
        commit_arch  = '0;
        num_commit   = '0;
        scan_run     = !flush_now;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (scan_run && valid_q[lane_idx[k]] && ready_q[lane_idx[k]]) begin
                commit_valid[k] = 1'b1;
                commit_phys[k]  = phys_q[lane_idx[k]];
                commit_arch[k]  = arch_q[lane_idx[k]];
                num_commit      = num_commit + PTR_ONE;
            end else begin
                scan_run = 1'b0;
            end
        end
    end

    // Completions only touch entries valid before the edge, so a CDB for the
    // slot being allocated this cycle is dropped and cannot collide with a commit.
    always_comb begin
        head_d  = head_q + num_commit;
        tail_d  = tail_q;
        valid_d = valid_q;
        ready_d = ready_q;
        phys_d  = phys_q;
        arch_d  = arch_q;
        for (int p = 0; p < CDB_PORTS; p++) begin
            if (bus.cdb_valid[p] && valid_q[bus.cdb_rob_idx[p]]) begin
                ready_d[bus.cdb_rob_idx[p]] = 1'b1;
            end
        end
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (commit_valid[k]) begin
                valid_d[lane_idx[k]] = 1'b0;
                ready_d[lane_idx[k]] = 1'b0;
            end
        end
        if (do_enq) begin
            valid_d[tail_q[ADDR_W-1:0]] = 1'b1;
            ready_d[tail_q[ADDR_W-1:0]] = 1'b0;
            phys_d[tail_q[ADDR_W-1:0]]  = bus.phys_reg_in;
            arch_d[tail_q[ADDR_W-1:0]]  = bus.arch_reg_in;
            tail_d                      = tail_q + PTR_ONE;
        end
        if (flush_now) begin
            valid_d = '0;
            ready_d = '0;
            head_d  = '0;
            tail_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            ready_q <= '0;
            phys_q  <= '{default: '0};
            arch_q  <= '{default: '0};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            phys_q  <= phys_d;
            arch_q  <= arch_d;
        end
    end
endmodule

// File: tb/tb_rob_multi.sv
// Directed, table-driven bench for rob_multi (default parameters).
// Define ROB_FLUSH_EN for both RTL and bench to include the flush sequence.
module tb_rob_multi;
    typedef struct {
        logic       enq;
        logic [5:0] phys;
        logic [4:0] arch;
        logic [1:0] cdbv;
        logic [5:0] idx0;
        logic [5:0] idx1;
        logic       flush;
        logic [1:0] ecv;
        logic [5:0] ep0;
        logic [5:0] ep1;
        logic [4:0] ea0;
        logic [4:0] ea1;
        logic [6:0] ecnt;
        logic       efull;
        logic       eempty;
        logic [5:0] ern;
    } vec_t;

    logic clk;
    logic rst;
`ifdef ROB_FLUSH_EN
    logic flush;
`endif
    int   n_cmp;
    int   n_err;
    vec_t tbl [21];
    vec_t r;

    rob_multi_if #(.QUEUE_DEPTH(64), .PHYS_REG_WIDTH(6), .ARCH_REG_WIDTH(5),
                   .CDB_PORTS(2), .COMMIT_WIDTH(2)) bus ();

    rob_multi #(.QUEUE_DEPTH(64), .PHYS_REG_WIDTH(6), .ARCH_REG_WIDTH(5),
                .CDB_PORTS(2), .COMMIT_WIDTH(2)) dut (
        .clk  (clk),
        .rst  (rst),
`ifdef ROB_FLUSH_EN
        .flush(flush),
`endif
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input int enq, input int ph, input int ar, input int cv,
                                input int i0, input int i1, input int ecv, input int p0,
                                input int p1, input int a0, input int a1, input int cnt,
                                input int rn);
        vec_t v;
        v.enq    = (enq != 0);
        v.phys   = 6'(ph);
        v.arch   = 5'(ar);
        v.cdbv   = 2'(cv);
        v.idx0   = 6'(i0);
        v.idx1   = 6'(i1);
        v.flush  = 1'b0;
        v.ecv    = 2'(ecv);
        v.ep0    = 6'(p0);
        v.ep1    = 6'(p1);
        v.ea0    = 5'(a0);
        v.ea1    = 5'(a1);
        v.ecnt   = 7'(cnt);
        v.efull  = (cnt == 64);
        v.eempty = (cnt == 0);
        v.ern    = 6'(rn);
        return v;
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setInputs(input vec_t v);
        bus.enqueue_valid  = v.enq;
        bus.phys_reg_in    = v.phys;
        bus.arch_reg_in    = v.arch;
        bus.cdb_valid      = v.cdbv;
        bus.cdb_rob_idx[0] = v.idx0;
        bus.cdb_rob_idx[1] = v.idx1;
`ifdef ROB_FLUSH_EN
        flush              = v.flush;
`endif
    endtask

    task automatic checkOutput(input vec_t v, input string name);
        cmp({name, ".commit_valid"}, int'(bus.commit_valid), int'(v.ecv));
        if (v.ecv[0]) begin
            cmp({name, ".phys0"}, int'(bus.commit_phys[0]), int'(v.ep0));
            cmp({name, ".arch0"}, int'(bus.commit_arch[0]), int'(v.ea0));
        end
        if (v.ecv[1]) begin
            cmp({name, ".phys1"}, int'(bus.commit_phys[1]), int'(v.ep1));
            cmp({name, ".arch1"}, int'(bus.commit_arch[1]), int'(v.ea1));
        end
        cmp({name, ".count"}, int'(bus.count), int'(v.ecnt));
        cmp({name, ".full"}, int'(bus.full), int'(v.efull));
        cmp({name, ".empty"}, int'(bus.empty), int'(v.eempty));
        cmp({name, ".rob_num"}, int'(bus.rob_num), int'(v.ern));
        cmp({name, ".enqueue_ready"}, int'(bus.enqueue_ready), int'(!v.efull));
    endtask

    task automatic applyStimulus(input vec_t v, input string name);
        setInputs(v);
        #1;
        checkOutput(v, name);
        tick();
    endtask

    task automatic doReset();
        setInputs(mk(0,0,0,0,0,0, 0,0,0,0,0, 0,0));
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Streams entries lo..hi, completing each one the cycle after allocation,
    // then drains so head == tail == hi+1.
    task automatic streamRun(input int lo, input int hi);
        vec_t s;
        for (int i = lo; i <= hi; i++) begin
            s = mk(1, i, i, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            if (i > lo) begin
                s.cdbv[0] = 1'b1;
                s.idx0    = 6'(i - 1);
            end
            if (i == 2) begin
                s.cdbv[1] = 1'b1;
                s.idx1    = 6'd40;
                s.ecv     = 2'b01;
                s.ecnt    = 7'd2;
                s.eempty  = 1'b0;
                s.ern     = 6'd2;
                applyStimulus(s, "inval_cdb40");
            end else begin
                setInputs(s);
                tick();
            end
        end
        setInputs(mk(0, 0, 0, 1, hi, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        setInputs(mk(0,0,0,0,0,0, 0,0,0,0,0, 0,0));
        tick();
        tick();
        applyStimulus(mk(0,0,0,0,0,0, 0,0,0,0,0, 0, hi + 1), "drain");
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        clk   = 1'b0;
        rst   = 1'b0;
        tbl[0]  = mk(0, 0, 0, 0,  0, 0, 0,  0,  0, 0, 0, 0, 0);
        tbl[1]  = mk(1,10, 1, 0,  0, 0, 0,  0,  0, 0, 0, 0, 0);
        tbl[2]  = mk(1,11, 2, 0,  0, 0, 0,  0,  0, 0, 0, 1, 1);
        tbl[3]  = mk(1,12, 3, 0,  0, 0, 0,  0,  0, 0, 0, 2, 2);
        tbl[4]  = mk(0, 0, 0, 3,  0, 1, 0,  0,  0, 0, 0, 3, 3);
        tbl[5]  = mk(0, 0, 0, 0,  0, 0, 3, 10, 11, 1, 2, 3, 3);
        tbl[6]  = mk(1,13, 4, 0,  0, 0, 0,  0,  0, 0, 0, 1, 3);
        tbl[7]  = mk(0, 0, 0, 1,  3, 0, 0,  0,  0, 0, 0, 2, 4);
        tbl[8]  = mk(0, 0, 0, 0,  0, 0, 0,  0,  0, 0, 0, 2, 4);
        tbl[9]  = mk(0, 0, 0, 2,  0, 2, 0,  0,  0, 0, 0, 2, 4);
        tbl[10] = mk(0, 0, 0, 0,  0, 0, 3, 12, 13, 3, 4, 2, 4);
        tbl[11] = mk(0, 0, 0, 1, 40, 0, 0,  0,  0, 0, 0, 0, 4);
        tbl[12] = mk(1,20, 5, 2,  0, 5, 0,  0,  0, 0, 0, 0, 4);
        tbl[13] = mk(0, 0, 0, 0,  0, 0, 0,  0,  0, 0, 0, 1, 5);
        tbl[14] = mk(0, 0, 0, 1,  4, 0, 0,  0,  0, 0, 0, 1, 5);
        tbl[15] = mk(0, 0, 0, 0,  0, 0, 1, 20,  0, 5, 0, 1, 5);
        tbl[16] = mk(1,21, 6, 0,  0, 0, 0,  0,  0, 0, 0, 0, 5);
        tbl[17] = mk(0, 0, 0, 0,  0, 0, 0,  0,  0, 0, 0, 1, 6);
        tbl[18] = mk(0, 0, 0, 1,  5, 0, 0,  0,  0, 0, 0, 1, 6);
        tbl[19] = mk(0, 0, 0, 0,  0, 0, 1, 21,  0, 6, 0, 1, 6);
        tbl[20] = mk(0, 0, 0, 0,  0, 0, 0,  0,  0, 0, 0, 0, 6);

        doReset();
        for (int i = 0; i < 21; i++) begin
            applyStimulus(tbl[i], $sformatf("tbl%0d", i));
        end

        // Reset in the middle of activity discards everything.
        setInputs(mk(1, 33, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        applyStimulus(mk(0,0,0,0,0,0, 0,0,0,0,0, 0,0), "midreset");

        // Fill to capacity, drop an overflow, then a same-cycle commit+enqueue.
        for (int i = 0; i < 64; i++) begin
            applyStimulus(mk(1, i, i, 0, 0, 0, 0, 0, 0, 0, 0, i, i), $sformatf("fill%0d", i));
        end
        applyStimulus(mk(1, 55, 7, 0, 0, 0, 0, 0, 0, 0, 0, 64, 0), "overflow");
        applyStimulus(mk(0,  0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 64, 0), "full_cdb0");
        applyStimulus(mk(1, 50, 9, 0, 0, 0, 1, 0, 0, 0, 0, 64, 0), "commit_enq");
        applyStimulus(mk(1, 50, 9, 0, 0, 0, 0, 0, 0, 0, 0, 63, 0), "retry_enq");
        applyStimulus(mk(0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64, 1), "refilled");

        // Stale CDB to index 40 must not pre-mark it; then wrap-around commit.
        doReset();
        streamRun(0, 39);
        applyStimulus(mk(1, 40, 8, 0,  0, 0, 0,  0, 0, 0, 0, 0, 40), "enq40");
        applyStimulus(mk(0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 1, 41), "e40_notready");
        applyStimulus(mk(0,  0, 0, 1, 40, 0, 0,  0, 0, 0, 0, 1, 41), "cdb40");
        applyStimulus(mk(0,  0, 0, 0,  0, 0, 1, 40, 0, 8, 0, 1, 41), "commit40");
        streamRun(41, 61);
        applyStimulus(mk(1, 30, 1, 0,  0, 0, 0,  0,  0, 0, 0, 0, 62), "wrap_enq62");
        applyStimulus(mk(1, 31, 2, 0,  0, 0, 0,  0,  0, 0, 0, 1, 63), "wrap_enq63");
        applyStimulus(mk(1, 32, 3, 0,  0, 0, 0,  0,  0, 0, 0, 2,  0), "wrap_enq0");
        applyStimulus(mk(0,  0, 0, 3, 63, 0, 0,  0,  0, 0, 0, 3,  1), "wrap_cdb63_0");
        applyStimulus(mk(0,  0, 0, 1, 62, 0, 0,  0,  0, 0, 0, 3,  1), "wrap_cdb62");
        applyStimulus(mk(0,  0, 0, 0,  0, 0, 3, 30, 31, 1, 2, 3,  1), "wrap_commit2");
        applyStimulus(mk(0,  0, 0, 0,  0, 0, 1, 32,  0, 3, 0, 1,  1), "wrap_commit0");
        applyStimulus(mk(0,  0, 0, 0,  0, 0, 0,  0,  0, 0, 0, 0,  1), "wrap_empty");

`ifdef ROB_FLUSH_EN
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(mk(1, i + 1, i + 1, 0, 0, 0, 0, 0, 0, 0, 0, i, i), $sformatf("fl_enq%0d", i));
        end
        applyStimulus(mk(0, 0, 0, 3, 0, 1, 0, 0, 0, 0, 0, 5, 5), "fl_cdb");
        r = mk(1, 9, 9, 3, 2, 3, 0, 0, 0, 0, 0, 5, 5);
        r.flush = 1'b1;
        applyStimulus(r, "fl_flush");
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "fl_after");
        applyStimulus(mk(1, 7, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "fl_enq_new");
        applyStimulus(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1), "fl_cdb_new");
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 1, 7, 0, 7, 0, 1, 1), "fl_commit_new");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rob_multi.md
# rob_multi

Parametrised multi-port reorder buffer: the out-of-order core's in-order retirement queue, generalised to configurable depth, register widths, CDB port count and commit width, with optional pipeline flush. One entry is allocated per cycle at rename/dispatch. Completion is marked from several CDB ports. Up to COMMIT_WIDTH consecutive ready entries retire per cycle to the RRF.

## Interface
- QUEUE_DEPTH, 64, number of entries; power of two, at least 4
- PHYS_REG_WIDTH, 6, physical register tag width
- ARCH_REG_WIDTH, 5, architectural register index width
- CDB_PORTS, 2, number of completion broadcast ports
- COMMIT_WIDTH, 2, maximum retirements per cycle; at least 1 and at most QUEUE_DEPTH
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  synchronous, active-low reset (rst==0 at posedge resets)
- enqueue_valid  in  1  dispatch requests allocation this cycle
- phys_reg_in  in  PHYS_REG_WIDTH  destination physical tag
- arch_reg_in  in  ARCH_REG_WIDTH  destination architectural register
- enqueue_ready  out  1  equals !full; allocation happens only if enqueue_valid && enqueue_ready
- rob_num  out  $clog2(QUEUE_DEPTH)  index the next allocation will receive (tail)
- cdb_valid  in  CDB_PORTS  per-port completion strobe
- cdb_rob_idx  in  CDB_PORTS x $clog2(QUEUE_DEPTH)  per-port completing entry index
- commit_valid  out  COMMIT_WIDTH  per-lane retire strobe; always contiguous from lane 0
- commit_phys  out  COMMIT_WIDTH x PHYS_REG_WIDTH  retiring physical tag per lane
- commit_arch  out  COMMIT_WIDTH x ARCH_REG_WIDTH  retiring architectural register per lane
- full  out  1  all QUEUE_DEPTH entries valid
- empty  out  1  no valid entries
- count  out  $clog2(QUEUE_DEPTH)+1  number of valid entries
- flush  in  1  present only with ROB_FLUSH_EN

## Operation
- Each entry holds: valid, ready, phys, arch. Head and tail pointers are ADDR_WIDTH+1 bits; the MSB is the wrap bit.
- full: low address bits equal and wrap bits differ. empty: pointers equal.
- Enqueue: writes {valid=1, ready=0, phys, arch} at tail. tail increments and wraps modulo 2·QUEUE_DEPTH.
- Completion: for each port p with cdb_valid[p], the entry at cdb_rob_idx[p] has ready set to 1 if that entry is valid. A completion to an invalid entry is ignored. Several ports naming the same index are harmless (OR).
- Commit: lane k is valid iff entries head+0..head+k are all valid and ready. The first not-ready or invalid entry stops the scan; there are no gaps.
- Retired entries have valid cleared. head advances by popcount(commit_valid).
- count = tail − head (full-width subtract). count updates by +enqueued − committed in the same cycle.
- Enqueue decision uses registered full only. A same-cycle commit does not free a slot for a same-cycle enqueue; that slot is usable next cycle.
- An enqueue_valid while full is dropped. State and tail are unchanged; dispatch must hold and retry.

## Timing
- Reset values: head=tail=0, all valid/ready=0, commit_valid=0, commit_phys/arch=0, full=0, empty=1, count=0, rob_num=0, enqueue_ready=1.
- commit_* outputs are combinational from registered state. The RRF samples them at the same posedge that updates head.
- Latency:
  - Enqueue at edge N; CDB for that entry at edge N+1 or later; ready visible after that edge; commit in the following cycle.
  - Minimum enqueue-to-commit is 2 cycles.
- A CDB write and a commit to the same entry in the same cycle cannot both apply: commit sees the pre-edge ready=0, so it commits next cycle.
- Wrap-around: commit lanes crossing index QUEUE_DEPTH−1 → 0 read modulo QUEUE_DEPTH.
- Reset asserted mid-operation discards all entries at that edge. Outputs take reset values the following cycle.

## Configuration
- ROB_FLUSH_EN defined:
  - Adds the flush input.
  - flush=1 at an edge clears all valid/ready bits and sets head=tail=0, count=0.
  - During the flush cycle, commit_valid is forced to 0, and enqueue and CDB inputs are ignored.
  - Reset has priority over flush.
- ROB_FLUSH_EN undefined: no flush port and no flush logic; behaviour otherwise identical.

## Test plan
- Reset, then enqueue 3 entries (phys 10/11/12, arch 1/2/3), then CDB ready for indices 0 and 1 on ports 0 and 1 in one cycle → the next cycle shows commit_valid=2'b11, phys 10/11, arch 1/2; count goes 3→1.
- Mark index 1 ready while index 0 is not → commit_valid=0. Then mark index 0 ready → the next cycle shows both retiring in order.
- Fill with 64 enqueues → full=1, enqueue_ready=0, count=64. A 65th enqueue is dropped, rob_num stays 0. Commit one entry and enqueue in that same cycle → the enqueue is refused; it succeeds the next cycle.
- Steady-state wrap: head=62, entries 62, 63, 0 all ready → lanes commit 62 and 63 in one cycle, then 0 the next cycle; head wraps with its wrap bit toggled.
- A CDB to an invalid index (e.g. 40 with count=2) leaves state unchanged. Later, an enqueue into index 40 starts with ready=0.
- With ROB_FLUSH_EN: 5 entries, 2 ready, flush=1 → no commit that cycle; the next cycle shows empty=1, count=0, rob_num=0.
